wb_rr_arbiter4: RTL and testbench

- Four-master to one-slave Wishbone B4 pipelined arbiter with round-robin fairness.
- Sits between the CPU-side masters (instruction fetch, load/store, DMA, debug) and the shared memory bus.
- Grant is registered; outstanding requests are tracked so the bus never holds more in flight than the slave can absorb.
- Forced one-clock idle gap between ownership changes.

---
 rtl/wb_rr_arbiter4.sv | 221 ++++++++++++++++++++++
 tb/tb_wb_rr_arbiter4.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter4.sv
// wb_rr_arbiter4
// Four-master to one-slave Wishbone B4 pipelined arbiter with round-robin
// fairness. Ownership is granted on a registered one-hot o_grant, held until
// the owning master drops its cyc, and followed by a forced one-clock idle
// gap before the next arbitration. The number of strobes in flight is
// tracked so the slave never sees more than 2^LGOUT-1 outstanding requests.
//
// Ports
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_cyc/i_stb/i_we      per-master Wishbone request bits (bit n = master n)
//   i_adr/i_dat/i_sel     per-master address/data/select, master n at [n*W +: W]
//   o_ack/o_stall/o_err   per-master responses
//   o_cyc..o_sel          slave-side request
//   i_ack/i_stall/i_err   slave-side responses
//   o_grant               one-hot current owner, 0 when the bus is unowned
//
// Configuration
//   WBRR_TIMEOUT_EN       when defined, an ack watchdog aborts a transfer that
//                         waits TIMEOUT clocks with requests outstanding and
//                         no ack; the owner sees a one-clock error and loses
//                         the bus. When undefined TIMEOUT is unused.

module wb_rr_arbiter4 #(
    parameter int DW      = 32,
    parameter int AW      = 19,
    parameter int LGOUT   = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [3:0]        i_cyc,
    input  logic [3:0]        i_stb,
    input  logic [3:0]        i_we,
    input  logic [4*AW-1:0]   i_adr,
    input  logic [4*DW-1:0]   i_dat,
    input  logic [4*DW/8-1:0] i_sel,
    output logic [3:0]        o_ack,
    output logic [3:0]        o_stall,
    output logic [3:0]        o_err,
    output logic              o_cyc,
    output logic              o_stb,
    output logic              o_we,
    output logic [AW-1:0]     o_adr,
    output logic [DW-1:0]     o_dat,
    output logic [DW/8-1:0]   o_sel,
    input  logic              i_ack,
    input  logic              i_stall,
    input  logic              i_err,
    output logic [3:0]        o_grant
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t           state;
    logic             r_cyc;
    // Last winner. While in OWN this is also the current owner, so the
    // request mux and response steering index off it directly.
    logic [1:0]       last;
    logic [LGOUT-1:0] count;
    logic [LGOUT-1:0] count_nxt;
    logic             full;
    logic             accept;
    logic             fire;
    logic [1:0]       winner;
    logic [1:0]       cand;
    logic             found;

    assign full = (count == {LGOUT{1'b1}});

    // ------------------------------------------------------------------
    // Slave-side request: the owner's signals pass straight through.
    // cyc follows the master combinationally so a release is visible to
    // the slave in the same clock the master drops cyc.
    // ------------------------------------------------------------------
    assign o_cyc = r_cyc & i_cyc[last] & ~fire;
    assign o_stb = o_cyc & i_stb[last] & ~full;
    assign o_we  = i_we[last];
    assign o_adr = i_adr[int'(last)*AW +: AW];
    assign o_dat = i_dat[int'(last)*DW +: DW];
    assign o_sel = i_sel[int'(last)*(DW/8) +: DW/8];

    // Strobe taken by the slave this clock.
    assign accept = o_stb & ~i_stall;

    // ------------------------------------------------------------------
    // Master-side responses: only the owner ever sees ack/err or a
    // non-stalled cycle; everybody else is held off.
    // ------------------------------------------------------------------
    always_comb begin
        o_stall = 4'hF;
        o_ack   = 4'h0;
        o_err   = 4'h0;
        if (r_cyc) begin
            o_stall[last] = i_stall | full;
        end
        if (o_cyc) begin
            o_ack[last] = i_ack;
            o_err[last] = i_err;
        end
        if (fire) begin
            o_err[last] = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Round-robin pick: scan (last+1) .. (last+4) mod 4; the 2-bit add
    // provides the wrap for free.
    // ------------------------------------------------------------------
    always_comb begin
        winner = last;
        cand   = last;
        found  = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            cand = last + 2'(k);
            if (!found && i_cyc[cand]) begin
                winner = cand;
                found  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outstanding counter next value. A strobe accepted in the same clock
    // as an ack leaves the count alone; a stray ack with nothing in flight
    // is ignored so the counter never wraps below zero. The count cannot
    // wrap upward because o_stb is masked while full.
    // ------------------------------------------------------------------
    always_comb begin
        count_nxt = count;
        if (accept && i_ack) begin
            count_nxt = count;
        end else if (accept) begin
            count_nxt = count + LGOUT'(1);
        end else if (i_ack && (count != '0)) begin
            count_nxt = count - LGOUT'(1);
        end
    end

`ifdef WBRR_TIMEOUT_EN
    // Ack watchdog: counts consecutive OWN clocks with something in flight
    // and no ack. It fires on the TIMEOUT-th such clock.
    localparam int WDW = $clog2(TIMEOUT + 1);

    logic [WDW-1:0] wdog;

    assign fire = r_cyc && (count != '0) && !i_ack &&
                  (wdog == WDW'(TIMEOUT - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst || (state != OWN)) begin
            wdog <= '0;
        end else if ((count != '0) && !i_ack) begin
            wdog <= wdog + WDW'(1);
        end else begin
            wdog <= '0;
        end
    end
`else
    logic unused_timeout;

    assign fire           = 1'b0;
    assign unused_timeout = ^TIMEOUT;
`endif

    // ------------------------------------------------------------------
    // Ownership FSM. Arbitration happens only in IDLE, and every release
    // passes through GAP, so consecutive owners are separated by at least
    // two clocks without o_cyc.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= IDLE;
            o_grant <= 4'h0;
            r_cyc   <= 1'b0;
            last    <= 2'd3;
            count   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_cyc) begin
                        state   <= OWN;
                        o_grant <= 4'b0001 << winner;
                        r_cyc   <= 1'b1;
                        last    <= winner;
                        count   <= '0;
                    end
                end
                OWN: begin
                    if (!i_cyc[last] || fire) begin
                        // Release: anything still in flight is abandoned,
                        // late acks land in GAP/IDLE and are dropped.
                        state   <= GAP;
                        o_grant <= 4'h0;
                        r_cyc   <= 1'b0;
                        count   <= '0;
                    end else if (i_err) begin
                        // Bus error terminates all outstanding requests
                        // but the master keeps the bus until it lets go.
                        count <= '0;
                    end else begin
                        count <= count_nxt;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    o_grant <= 4'h0;
                    r_cyc   <= 1'b0;
                    count   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter4.sv
// Testbench for wb_rr_arbiter4: directed scenarios followed by randomized
// traffic, every cycle compared against a transaction-level model that
// tracks owner, last winner, gap pending and requests in flight as integers.

module tb_wb_rr_arbiter4;
    localparam int DW    = 32;
    localparam int AW    = 19;
    localparam int LGOUT = 4;
    localparam int TO    = 48;
    localparam int CMAX  = (1 << LGOUT) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        cyc, stb, we;
    logic [4*AW-1:0]   adr;
    logic [4*DW-1:0]   dat;
    logic [4*DW/8-1:0] sel;
    logic [3:0]        ack, stall, err, grant;
    logic              b_cyc, b_stb, b_we;
    logic [AW-1:0]     b_adr;
    logic [DW-1:0]     b_dat;
    logic [DW/8-1:0]   b_sel;
    logic              s_ack, s_stall, s_err;

    wb_rr_arbiter4 #(.DW(DW), .AW(AW), .LGOUT(LGOUT), .TIMEOUT(TO)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_cyc(cyc), .i_stb(stb), .i_we(we),
        .i_adr(adr), .i_dat(dat), .i_sel(sel),
        .o_ack(ack), .o_stall(stall), .o_err(err),
        .o_cyc(b_cyc), .o_stb(b_stb), .o_we(b_we),
        .o_adr(b_adr), .o_dat(b_dat), .o_sel(b_sel),
        .i_ack(s_ack), .i_stall(s_stall), .i_err(s_err),
        .o_grant(grant)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference model
    int m_owner;  // -1 when unowned
    int m_last;
    int m_cnt;    // requests in flight
    int m_wd;     // consecutive quiet clocks with requests in flight
    bit m_gap;

    int cyc_no    = 0;
    int first_cyc = -1;
    int acc_seen  = 0;
    int ph[4];
    int order[$];
    logic [3:0] prev_g;
    int hand_n;
    int fire_at;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Called at posedge+1 with inputs for this clock already applied.
    // Checks outputs mid-cycle, advances the model, returns at next posedge+1.
    task automatic step();
        int         o, pc, n;
        bit         full, fire, e_cyc, e_stb;
        logic [3:0] e_stall, e_ack, e_err, e_grant;
        for (int i = 0; i < 4; i++) begin
            adr[i*AW +: AW]         = AW'($urandom);
            dat[i*DW +: DW]         = $urandom;
            sel[i*(DW/8) +: DW/8]   = (DW/8)'($urandom);
        end
        #4;
        o    = m_owner;
        full = (m_cnt == CMAX);
        fire = 1'b0;
`ifdef WBRR_TIMEOUT_EN
        fire = (o >= 0) && (m_cnt > 0) && !s_ack && (m_wd == TO - 1);
`endif
        e_cyc = 1'b0; e_stb = 1'b0;
        e_stall = 4'hF; e_ack = 4'h0; e_err = 4'h0; e_grant = 4'h0;
        if (o >= 0) begin
            e_grant[o] = 1'b1;
            e_cyc      = cyc[o] && !fire;
            e_stb      = e_cyc && stb[o] && !full;
            e_stall[o] = s_stall || full;
            e_ack[o]   = e_cyc && s_ack;
            e_err[o]   = (e_cyc && s_err) || fire;
        end
        chk("grant", grant, e_grant);
        chk("cyc", b_cyc, e_cyc);
        chk("stb", b_stb, e_stb);
        chk("stall", stall, e_stall);
        chk("ack", ack, e_ack);
        chk("err", err, e_err);
        if (o >= 0 && e_cyc) begin
            chk("we", b_we, we[o]);
            chk("adr", b_adr, adr[o*AW +: AW]);
            chk("dat", b_dat, dat[o*DW +: DW]);
            chk("sel", b_sel, sel[o*(DW/8) +: DW/8]);
        end
        if (b_stb && !s_stall) acc_seen++;
        if (b_cyc && first_cyc < 0) first_cyc = cyc_no;

        pc = m_cnt;
        if (rst) begin
            m_owner = -1; m_gap = 1'b0; m_last = 3; m_cnt = 0; m_wd = 0;
        end else if (o >= 0) begin
            if (!cyc[o] || fire) begin
                m_owner = -1; m_gap = 1'b1; m_cnt = 0; m_wd = 0;
            end else begin
                if (s_err)                          m_cnt = 0;
                else if (e_stb && !s_stall && s_ack) m_cnt = pc;
                else if (e_stb && !s_stall)          m_cnt = pc + 1;
                else if (s_ack && pc > 0)            m_cnt = pc - 1;
                m_wd = (pc > 0 && !s_ack) ? m_wd + 1 : 0;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (cyc != 4'h0) begin
            for (int k = 1; k <= 4; k++) begin
                n = (m_last + k) % 4;
                if (cyc[n] && m_owner < 0) begin
                    m_owner = n;
                    m_last  = n;
                end
            end
        end
        cyc_no++;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_owner(input int n);
        for (int i = 0; i < 8 && m_owner != n; i++) step();
        chk("wait_grant", grant, 4'b0001 << n);
    endtask

    task automatic idle_out();
        cyc = 4'h0; stb = 4'h0; s_ack = 1'b0; s_err = 1'b0; s_stall = 1'b0;
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL sim_timeout: got no finish expected finish");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        rst = 1'b1; cyc = 4'h0; stb = 4'h0; we = 4'h0;
        adr = '0; dat = '0; sel = '0;
        s_ack = 1'b0; s_stall = 1'b0; s_err = 1'b0;
        m_owner = -1; m_gap = 1'b0; m_last = 3; m_cnt = 0; m_wd = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_grant", grant, 4'h0);
        chk("rst_cyc", b_cyc, 1'b0);
        chk("rst_stall", stall, 4'hF);
        chk("rst_ack", ack, 4'h0);
        chk("rst_err", err, 4'h0);

        // all four request single-beat cycles together
        for (int i = 0; i < 4; i++) ph[i] = 0;
        cyc = 4'hF; first_cyc = -1; prev_g = 4'h0;
        hand_n = cyc_no;
        for (int t = 0; t < 60 && cyc != 4'h0; t++) begin
            s_ack = 1'b0;
            if (m_owner >= 0) begin
                case (ph[m_owner])
                    0: begin stb[m_owner] = 1'b1; ph[m_owner] = 1; end
                    1: begin stb[m_owner] = 1'b0; s_ack = 1'b1; ph[m_owner] = 2; end
                    default: cyc[m_owner] = 1'b0;
                endcase
            end
            step();
            if (grant != 4'h0 && grant != prev_g)
                for (int i = 0; i < 4; i++) if (grant[i]) order.push_back(i);
            prev_g = grant;
        end
        chk("req_to_cyc", first_cyc - hand_n, 1);
        chk("rr_order_len", order.size(), 4);
        for (int i = 0; i < 4 && i < order.size(); i++) chk("rr_order", order[i], i);
        idle_out();

        // master 2 fills the outstanding window with no acks
        cyc = 4'b0100;
        wait_owner(2);
        stb[2] = 1'b1; acc_seen = 0;
        repeat (20) step();
        chk("fill_acc", acc_seen, CMAX);
        chk("fill_stall", stall[2], 1'b1);
        s_ack = 1'b1; step(); s_ack = 1'b0;
        step();
        chk("refill_acc", acc_seen, CMAX + 1);
        idle_out();

        // master 0 waits behind master 1 with 3 outstanding
        cyc = 4'b0010;
        wait_owner(1);
        stb[1] = 1'b1; repeat (3) step(); stb[1] = 1'b0;
        cyc[0] = 1'b1; stb[0] = 1'b1;
        s_ack = 1'b1; step(); s_ack = 1'b0;
        repeat (4) step();
        chk("m0_wait_stall", stall[0], 1'b1);
        chk("m0_wait_grant", grant, 4'b0010);
        cyc[1] = 1'b0; stb[0] = 1'b0; hand_n = 0;
        for (int i = 0; i < 8 && grant != 4'b0001; i++) begin step(); hand_n++; end
        chk("handover_clks", hand_n, 3);
        idle_out();

        // error while master 3 has 5 in flight
        cyc = 4'b1000;
        wait_owner(3);
        stb[3] = 1'b1; repeat (5) step(); stb[3] = 1'b0;
        s_err = 1'b1;
        #1 chk("err_pulse", err, 4'b1000);
        step();
        s_err = 1'b0;
        #1 chk("err_one_clk", err, 4'h0);
        chk("err_keep_grant", grant, 4'b1000);
        stb[3] = 1'b1; acc_seen = 0;
        repeat (17) step();
        chk("err_cnt_clr", acc_seen, CMAX);
        idle_out();

        // reset mid-burst with 7 in flight
        cyc = 4'b0010;
        wait_owner(1);
        stb[1] = 1'b1; repeat (7) step(); stb[1] = 1'b0;
        cyc[0] = 1'b1;
        rst = 1'b1; step(); rst = 1'b0;
        chk("mrst_cyc", b_cyc, 1'b0);
        chk("mrst_grant", grant, 4'h0);
        chk("mrst_stall", stall, 4'hF);
        step();
        chk("mrst_first_grant", grant, 4'b0001);
        idle_out();

`ifdef WBRR_TIMEOUT_EN
        // watchdog: one request in flight, slave never acks
        cyc = 4'b0100;
        wait_owner(2);
        stb[2] = 1'b1; step(); stb[2] = 1'b0;
        cyc[0] = 1'b1; fire_at = -1;
        for (int k = 1; k <= TO + 4 && fire_at < 0; k++) begin
            #1;
            if (err[2]) begin
                fire_at = k;
                chk("wdog_cyc", b_cyc, 1'b0);
            end
            step();
        end
        chk("wdog_clks", fire_at, TO);
        wait_owner(0);
        idle_out();
`endif

        // randomized traffic
        for (int t = 0; t < 3000; t++) begin
            for (int n = 0; n < 4; n++) begin
                if (!cyc[n]) cyc[n] = ($urandom_range(7, 0) == 0);
                else if ($urandom_range(15, 0) == 0) cyc[n] = 1'b0;
                stb[n] = cyc[n] & 1'($urandom);
                we[n]  = 1'($urandom);
            end
            s_stall = ($urandom_range(3, 0) == 0);
            s_ack   = (m_cnt > 0) ? ($urandom_range(2, 0) == 0) : ($urandom_range(19, 0) == 0);
            s_err   = ($urandom_range(63, 0) == 0);
            rst     = ($urandom_range(499, 0) == 0);
            step();
        end
        rst = 1'b0;
        idle_out();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
